mix_wt_writer: RTL
==================

# mix_wt_writer

Write-side sequencer for the mix-layer weight RAM (`mix_ram_wt`). It accepts a valid/ready stream of packed weight words (updated weights from the optimizer, or a host reload) and drives the RAM's `load`/`waddr`/`wdata` port. It addresses W_1, W_2 and W_3 as three contiguous sections of one RAM, writing either one section or all three in one run. It reports progress to the training controller through `busy` and `done`.

## Interface
- `ADDR_WIDTH`, 9: RAM word-address width; must satisfy 3*SEC_DEPTH ≤ 2^ADDR_WIDTH.
- `DATA_WIDTH`, `DATA_N*N_LEN_W`: one packed RAM word of DATA_N weights.
- `SEC_DEPTH`, `HID_DIM*HID_DIM/DATA_N`: words per weight matrix section.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  start pulse; sampled only in IDLE.
- `sel`  in  2  section select, sampled with `run`: 0=W_1, 1=W_2, 2=W_3, 3=all three.
- `abort`  in  1  terminates the current run.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DATA_WIDTH  stream word.
- `s_ready`  out  1  stream accept.
- `load`  out  1  RAM write enable.
- `waddr`  out  ADDR_WIDTH  RAM write address.
- `wdata`  out  DATA_WIDTH  RAM write data.
- `busy`  out  1  high from the cycle after `run` is accepted until `done`/abort completes.
- `done`  out  1  one-cycle completion pulse.

## Operation
- The module has one clock domain and a single clock, `clk`. Reset is `rst`: asynchronous and active-high.
- FSM states: IDLE, WRITE, FLUSH, DONE.
- IDLE: `s_ready`=0. On `run`=1, latch base and length, clear the word counter `cnt`, and go to WRITE.
  - `sel`<3: base = sel*SEC_DEPTH, length = SEC_DEPTH.
  - `sel`=3: base = 0, length = 3*SEC_DEPTH.
- WRITE: `s_ready`=1. Each beat (`s_valid & s_ready`) registers `load`=1, `waddr`=base+cnt and `wdata`=s_data, then increments `cnt`.
  - A cycle without a beat registers `load`=0; `waddr` and `wdata` hold their values.
  - The beat with cnt=length-1 moves the FSM to FLUSH.
- FLUSH: `s_ready`=0. The registered `load` for the last word is visible during this cycle. Next state is DONE.
- DONE: `done`=1 for one cycle, `busy` falls in the same cycle, and the FSM returns to IDLE.
- `abort`=1 in WRITE or FLUSH: go to IDLE next cycle.
  - No `done` pulse is produced.
  - A beat accepted in the abort cycle is still written.
  - Words already written remain in the RAM.
- `abort` in IDLE or DONE has no effect.
- `run` outside IDLE is ignored and has no side effect.
- The address adder is ADDR_WIDTH bits; `cnt` is ADDR_WIDTH bits. The sum never exceeds 3*SEC_DEPTH-1, so it never wraps.

## Timing
- Reset values: `s_ready`=0, `load`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0, state=IDLE, `cnt`=0.
- Reset asserted mid-run returns every output to its reset value immediately. The partial section is left in the RAM as written.
- `s_ready` is decoded from registered state only; it has no combinational path from `s_valid`.
- Latency: a beat accepted at cycle N appears on `load`/`waddr`/`wdata` at cycle N+1.
- Full throughput is one word per cycle. A section of L words with `s_valid` held high takes L cycles in WRITE.
- `done` comes 2 cycles after the last beat; `run` can be accepted in the cycle after `done`.
- `s_ready` is 0 in the cycle after the last beat, so the stream sees backpressure exactly at the section boundary.
- `load` is never high in two different runs without an intervening IDLE cycle.

## Structure
- `SEC_DEPTH` and the `sel` encodings (SEL_W1/SEL_W2/SEL_W3/SEL_ALL) go in `consts_train.vh` beside `HID_DIM`/`DATA_N`/`N_LEN_W`. `mix_ram_wt` and the matching read sequencer use the same definitions.
- This is a single module; no sub-module is warranted. The bench instantiates it feeding a real `mix_ram_wt` and checks writes by reading the RAM back.

## Test plan
- Reset, then `run` with sel=1 and a continuous stream with data=index → `load` pulses at waddr S..2S-1 (S=SEC_DEPTH) with matching data; `done` 2 cycles after the last beat; RAM readback matches.
- sel=3 with random `s_valid` gaps (~30%) → exactly 3S `load` pulses at addresses 0..3S-1 in order, with no address skipped or repeated; `s_ready` low only in IDLE/FLUSH/DONE.
- `run` pulsed again at word 5 of a sel=0 run → ignored; write sequence and `done` unchanged.
- `abort` at word 10 of sel=2, with a beat in the same cycle → writes at 2S..2S+10 only; no `done`; `busy` low next cycle; a following `run` sel=2 completes normally.
- `rst` asserted at word 7 of sel=0 → all outputs 0 asynchronously; after release, a new sel=0 run starts its writes at waddr 0.
- Back-to-back runs, sel=0 then sel=2 with `run` issued in the cycle after `done` → accepted; the second run's first write is at waddr 2S.

Source files
------------

// File: rtl/mix_wt_writer_pkg.sv
// Shared constants for the mix-layer weight RAM and its sequencers.
// Section geometry, select encodings and the writer FSM state type.
package mix_wt_writer_pkg;

  localparam int HID_DIM = 8;
  localparam int DATA_N  = 4;
  localparam int N_LEN_W = 8;

  localparam int DEF_SEC_DEPTH = HID_DIM * HID_DIM / DATA_N;

  localparam logic [1:0] SEL_W1  = 2'd0;
  localparam logic [1:0] SEL_W2  = 2'd1;
  localparam logic [1:0] SEL_W3  = 2'd2;
  localparam logic [1:0] SEL_ALL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FLUSH,
    ST_DONE
  } wr_state_t;

endpackage

// File: rtl/mix_wt_writer.sv
// Write-side sequencer for mix_ram_wt: streams packed weight words
// into one W section (or all three) and reports busy/done.
module mix_wt_writer
  import mix_wt_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = DATA_N * N_LEN_W,
  parameter int SEC_DEPTH  = DEF_SEC_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [1:0]            sel,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  load,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] SEC_A = ADDR_WIDTH'(SEC_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALL_A = ADDR_WIDTH'(3 * SEC_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  wr_state_t             state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] last;
  logic [ADDR_WIDTH-1:0] cnt;

  // Ready comes from registered state only, never from s_valid.
  assign s_ready = (state == ST_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      base  <= '0;
      last  <= '0;
      cnt   <= '0;
      load  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            if (sel == SEL_ALL) begin
              base <= '0;
              last <= ALL_A - ONE_A;
            end else begin
              base <= SEC_A * ADDR_WIDTH'(sel);
              last <= SEC_A - ONE_A;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (s_valid) begin
            load  <= 1'b1;
            waddr <= base + cnt;
            wdata <= s_data;
            cnt   <= cnt + ONE_A;
          end
          // A beat in the abort cycle is still written above.
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (s_valid && cnt == last) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          busy  <= 1'b0;
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
